// File: rtl/bbox_sweep_sequencer.sv
// Sweeps one ray across a contiguous run of boxes through a 3-cycle intersect pipe
// and reduces the hit stream to the closest hit (lowest index wins a distance tie).
module bbox_sweep_sequencer #(
  parameter int MAX_BOXES = 64,
  parameter int IDX_W     = $clog2(MAX_BOXES),
  parameter int ADDR_W    = 16,
  parameter int COORD_W   = 32,
  parameter int FIX_W     = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ray_valid,
  output logic                   ray_ready,
  input  logic [3*COORD_W-1:0]   ray_orig,
  input  logic [3*FIX_W-1:0]     inv_ray_dir,
  input  logic [2:0]             div_by_zero,
  input  logic [ADDR_W-1:0]      box_base,
  input  logic [IDX_W:0]         box_count,
  output logic                   box_req,
  output logic [ADDR_W-1:0]      box_addr,
  input  logic                   box_gnt,
  input  logic [6*COORD_W-1:0]   box_data,
  output logic                   isect_stall,
  output logic [3*COORD_W-1:0]   isect_ray_orig,
  output logic [3*FIX_W-1:0]     isect_inv_dir,
  output logic [2:0]             isect_dbz,
  output logic [6*COORD_W-1:0]   isect_box,
  input  logic                   isect_hit,
  input  logic signed [48:0]     isect_dist,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_hit,
  output logic [IDX_W-1:0]       res_index,
  output logic signed [48:0]     res_dist
);
  localparam int STAGES = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic signed [48:0] INF_DIST = {1'b0, {48{1'b1}}};
  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_BOXES);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  logic [1:0]                   state;
  logic [ADDR_W-1:0]            base_q;
  logic [IDX_W:0]               cnt_q, issue_idx, issue_inc, cnt_in;
  logic [3*COORD_W-1:0]         orig_q;
  logic [3*FIX_W-1:0]           dir_q;
  logic [2:0]                   dbz_q;
  logic [STAGES:1]              vld_pipe;
  logic [STAGES:1][IDX_W-1:0]   idx_pipe;
  logic signed [48:0]           best_dist;
  logic [IDX_W-1:0]             best_idx;
  logic                         any_hit;
  logic                         advance, push_vld, last_issue, take;

  assign cnt_in     = (box_count > MAX_CNT) ? MAX_CNT : box_count;
  assign issue_inc  = issue_idx + CNT_ONE;
  assign last_issue = (issue_inc == cnt_q);
  assign advance    = (state == S_ISSUE) || (state == S_DRAIN);
  assign push_vld   = (state == S_ISSUE) && box_gnt;
  // Stage 3 of the tag pipe lines up with the intersect unit's result.
  assign take       = advance && vld_pipe[STAGES] && isect_hit && (isect_dist < best_dist);

  assign ray_ready      = (state == S_IDLE);
  assign box_req        = (state == S_ISSUE);
  assign box_addr       = (state == S_ISSUE) ? base_q + ADDR_W'(issue_idx) : '0;
  assign isect_stall    = !advance;
  assign isect_ray_orig = orig_q;
  assign isect_inv_dir  = dir_q;
  assign isect_dbz      = dbz_q;
  assign isect_box      = box_data;
  assign res_valid      = (state == S_DONE);
  assign res_hit        = any_hit;
  assign res_index      = best_idx;
  assign res_dist       = best_dist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      issue_idx <= '0;
      orig_q    <= '0;
      dir_q     <= '0;
      dbz_q     <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      best_dist <= INF_DIST;
      best_idx  <= '0;
      any_hit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ray_valid) begin
          orig_q    <= ray_orig;
          dir_q     <= inv_ray_dir;
          dbz_q     <= div_by_zero;
          base_q    <= box_base;
          cnt_q     <= cnt_in;
          issue_idx <= '0;
          best_dist <= INF_DIST;
          best_idx  <= '0;
          any_hit   <= 1'b0;
          state     <= (cnt_in == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (box_gnt) begin
          issue_idx <= issue_inc;
          if (last_issue) state <= S_DRAIN;
        end
        // Stage 3 is reduced this cycle, so only stages 1-2 decide the exit.
        S_DRAIN: if (!vld_pipe[1] && !vld_pipe[2]) state <= S_DONE;
        S_DONE:  if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], push_vld};
        idx_pipe <= {idx_pipe[STAGES-1:1], issue_idx[IDX_W-1:0]};
      end
      if (take) begin
        best_dist <= isect_dist;
        best_idx  <= idx_pipe[STAGES];
        any_hit   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bbox_sweep_sequencer.sv
// Random and directed sweeps against a list-level model: memory, grant list and
// intersect pipe are emulated, expected result/latency come from plain loops.
module tb_bbox_sweep_sequencer;
  localparam int MAX_BOXES = 64;
  localparam int IDX_W     = 6;
  localparam int ADDR_W    = 16;
  localparam logic signed [48:0] INF = {1'b0, {48{1'b1}}};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ray_valid;
  logic                 ray_ready;
  logic [95:0]          ray_orig;
  logic [107:0]         inv_ray_dir;
  logic [2:0]           div_by_zero;
  logic [ADDR_W-1:0]    box_base;
  logic [IDX_W:0]       box_count;
  logic                 box_req;
  logic [ADDR_W-1:0]    box_addr;
  logic                 box_gnt;
  logic [191:0]         box_data;
  logic                 isect_stall;
  logic [95:0]          isect_ray_orig;
  logic [107:0]         isect_inv_dir;
  logic [2:0]           isect_dbz;
  logic [191:0]         isect_box;
  logic                 isect_hit;
  logic signed [48:0]   isect_dist;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_hit;
  logic [IDX_W-1:0]     res_index;
  logic signed [48:0]   res_dist;

  always #5 clk = ~clk;

  bbox_sweep_sequencer #(.MAX_BOXES(MAX_BOXES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_orig(ray_orig),
    .inv_ray_dir(inv_ray_dir), .div_by_zero(div_by_zero),
    .box_base(box_base), .box_count(box_count),
    .box_req(box_req), .box_addr(box_addr), .box_gnt(box_gnt), .box_data(box_data),
    .isect_stall(isect_stall), .isect_ray_orig(isect_ray_orig),
    .isect_inv_dir(isect_inv_dir), .isect_dbz(isect_dbz), .isect_box(isect_box),
    .isect_hit(isect_hit), .isect_dist(isect_dist),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_index(res_index), .res_dist(res_dist)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-box model data, grant list and emulated 3-deep request history
  logic               hit_a  [0:127];
  logic signed [48:0] dist_a [0:127];
  logic [191:0]       mem    [0:127];
  logic               gl     [0:511];
  int                 gl_len;
  logic [3:1]         dv;
  int                 di [1:3];
  logic               req_s, gnt_s;
  logic [15:0]        addr_s, cur_base;
  int                 gl_pos, grants, req_cycles;

  task automatic cycle();
    logic [15:0] off;
    @(posedge clk);
    off   = addr_s - cur_base;
    dv    = {dv[2:1], req_s & gnt_s};
    di[3] = di[2];
    di[2] = di[1];
    di[1] = int'(off);
    #1;
    if (dv[1] && di[1] < 128) box_data = mem[di[1]];
    else box_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    // bubbles carry a tempting near-zero hit that must be ignored
    if (dv[3] && di[3] < 128) begin
      isect_hit  = hit_a[di[3]];
      isect_dist = dist_a[di[3]];
    end else begin
      isect_hit  = 1'b1;
      isect_dist = 49'($urandom_range(0, 15));
    end
    chk("isect_box", 64'(isect_box != box_data), 64'(0));
    req_s = box_req;
    addr_s = box_addr;
    gnt_s = 1'b0;
    if (req_s) begin
      gnt_s = (gl_pos < gl_len) ? gl[gl_pos] : 1'b1;
      gl_pos++;
      req_cycles++;
      chk("box_addr", 64'(addr_s), 64'(16'(cur_base + 16'(grants))));
      if (gnt_s) grants++;
    end
    box_gnt = gnt_s;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ray_ready"}, 64'(ray_ready), 64'(1));
    chk({nm, "_box_req"},   64'(box_req),   64'(0));
    chk({nm, "_box_addr"},  64'(box_addr),  64'(0));
    chk({nm, "_stall"},     64'(isect_stall), 64'(1));
    chk({nm, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({nm, "_res_hit"},   64'(res_hit),   64'(0));
    chk({nm, "_res_index"}, 64'(res_index), 64'(0));
    chk({nm, "_res_dist"},  64'(res_dist),  64'(INF));
  endtask

  task automatic clear_data();
    for (int i = 0; i < 128; i++) begin
      hit_a[i]  = 1'b0;
      dist_a[i] = 49'($urandom_range(1000, 5000));
      mem[i]    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic random_data();
    clear_data();
    for (int i = 0; i < 128; i++) begin
      hit_a[i]  = ($urandom_range(0, 2) == 0);
      dist_a[i] = 49'($urandom_range(16, 60));
    end
    gl_len = 300;
    for (int i = 0; i < 300; i++) gl[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sweep(input string nm, input int n_raw, input logic [15:0] base,
                       input int hold, input bit abort);
    int n, exp_req, ones, lat, ex_idx;
    logic ex_hit;
    logic signed [48:0] ex_d;
    logic [95:0] o_l;
    logic [107:0] d_l;
    logic [2:0] z_l;
    n = (n_raw > MAX_BOXES) ? MAX_BOXES : n_raw;
    ex_hit = 1'b0; ex_idx = 0; ex_d = INF;
    for (int i = 0; i < n; i++)
      if (hit_a[i] && dist_a[i] < ex_d) begin
        ex_hit = 1'b1; ex_idx = i; ex_d = dist_a[i];
      end
    exp_req = 0; ones = 0;
    while (ones < n) begin
      if (exp_req >= gl_len || gl[exp_req]) ones++;
      exp_req++;
    end
    o_l = {$urandom, $urandom, $urandom};
    d_l = 108'({$urandom, $urandom, $urandom, $urandom});
    z_l = 3'($urandom);
    chk({nm, "_ray_ready"}, 64'(ray_ready), 64'(1));
    ray_valid = 1'b1; ray_orig = o_l; inv_ray_dir = d_l; div_by_zero = z_l;
    box_base = base; box_count = 7'(n_raw);
    cur_base = base; grants = 0; gl_pos = 0; req_cycles = 0;
    cycle();
    ray_valid = 1'b0;
    ray_orig = {$urandom, $urandom, $urandom};
    inv_ray_dir = 108'({$urandom, $urandom, $urandom, $urandom});
    div_by_zero = 3'($urandom); box_base = 16'($urandom); box_count = 7'($urandom);
    if (abort) begin
      lat = 0;
      while (grants < n && lat < 400) begin cycle(); lat++; end
      chk({nm, "_reach_drain"}, 64'(lat < 400), 64'(1));
      cycle();
      rst_n = 1'b0;
      #1;
      chk_reset(nm);
      dv = '0; req_s = 1'b0; gnt_s = 1'b0; box_gnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      return;
    end
    lat = 1;
    while (!res_valid && lat < 400) begin
      chk({nm, "_stall"}, 64'(isect_stall), 64'(0));
      chk({nm, "_latch"}, 64'({isect_ray_orig, isect_inv_dir, isect_dbz} != {o_l, d_l, z_l}), 64'(0));
      cycle();
      lat++;
    end
    chk({nm, "_latency"},  64'(lat), 64'((n == 0) ? 1 : exp_req + 4));
    chk({nm, "_req_cyc"},  64'(req_cycles), 64'(exp_req));
    chk({nm, "_res_hit"},  64'(res_hit), 64'(ex_hit));
    chk({nm, "_res_idx"},  64'(res_index), 64'(ex_idx));
    chk({nm, "_res_dist"}, 64'(res_dist), 64'(ex_d));
    chk({nm, "_stall_dn"}, 64'(isect_stall), 64'(1));
    repeat (hold) begin
      cycle();
      chk({nm, "_hold_rdy"},  64'({ray_ready, res_valid, box_req}), 64'(3'b010));
      chk({nm, "_hold_res"},  64'({res_hit, res_index}), 64'({ex_hit, 6'(ex_idx)}));
      chk({nm, "_hold_dist"}, 64'(res_dist), 64'(ex_d));
      chk({nm, "_hold_lat"},  64'({isect_ray_orig, isect_inv_dir, isect_dbz} != {o_l, d_l, z_l}), 64'(0));
    end
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    chk({nm, "_ready_back"}, 64'({ray_ready, res_valid}), 64'(2'b10));
  endtask

  initial begin
    rst_n = 1'b0; ray_valid = 1'b0; res_ready = 1'b0; box_gnt = 1'b0;
    ray_orig = '0; inv_ray_dir = '0; div_by_zero = '0; box_base = '0; box_count = '0;
    box_data = '0; isect_hit = 1'b0; isect_dist = '0;
    dv = '0; req_s = 1'b0; gnt_s = 1'b0; addr_s = '0; cur_base = '0;
    di[1] = 0; di[2] = 0; di[3] = 0;
    gl_len = 0; gl_pos = 0; grants = 0; req_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;

    clear_data(); gl_len = 0;
    hit_a[1] = 1'b1; dist_a[1] = 49'd100;
    hit_a[3] = 1'b1; dist_a[3] = 49'd50;
    sweep("s1", 4, 16'h0100, 0, 1'b0);

    gl_len = 7;
    for (int i = 0; i < 7; i++) gl[i] = (i % 2 == 0);
    sweep("s4_denied", 4, 16'h0200, 0, 1'b0);

    clear_data(); gl_len = 0;
    hit_a[0] = 1'b1; dist_a[0] = 49'd200;
    hit_a[2] = 1'b1; dist_a[2] = 49'd200;
    sweep("s2_tie_wrap", 3, 16'hfffe, 10, 1'b0);

    sweep("s3_empty", 0, 16'h1234, 1, 1'b0);

    random_data();
    sweep("abort", 6, 16'h4000, 0, 1'b1);
    chk_reset("post_abort");
    random_data();
    sweep("after_abort", 5, 16'h4000, 2, 1'b0);

    random_data();
    sweep("clamp", 100, 16'hffc0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      random_data();
      sweep("rnd", $urandom_range(0, 70), 16'($urandom), $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
